fifo1_rr_arbiter: RTL and testbench
===================================

Name: fifo1_rr_arbiter

Overview:
- Shares one single-entry holding buffer among NREQ requesters using round-robin arbitration.
- Each requester uses the team's en/data/rdy write handshake; one consumer drains the buffer with the read_en/read_data/read_rdy handshake.
- The consumer also receives the source ID of the held item.
- Sits between multiple producer interfaces and a single one-deep channel, and replaces ad-hoc muxing in front of FIFO1-style stages.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 1, data width in bits per requester and on the read side.
- IDW, $clog2(NREQ), localparam, width of source ID and pointer.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset; one clock; reset is synchronous and active-high.
- req_en  input  NREQ  per-requester write request.
- req_data  input  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- req_rdy  output  NREQ  per-requester ready; one-hot or zero.
- read_en  input  1  consumer pops held item.
- read_data  output  DW  held data.
- read_src  output  IDW  index of requester that wrote the held item.
- read_rdy  output  1  buffer holds valid item.

Behaviour:
- States: EMPTY, FULL (single state bit; read_rdy = (state==FULL)).
- Reset (RST=1 at clock edge): state=EMPTY, read_data=0, read_src=0, rr pointer ptr=0. Any held item is discarded, including mid-transfer.
- Grant (combinational): gnt = first asserted req_en[i] scanning i = ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
- gnt is zero if no req_en is asserted.
- req_rdy = gnt when state==EMPTY, else all zero. req_rdy depends combinationally on req_en; requesters must not make req_en depend on req_rdy.
- Accept: when state==EMPTY and gnt[i], on the clock edge:
  - read_data <= req_data[i]; read_src <= i; state <= FULL.
  - ptr <= (i+1) mod NREQ, wrapping from NREQ-1 to 0.
- ptr changes only on accept; idle cycles leave it unchanged.
- In FULL: req_rdy all zero, no accept. When read_en=1, state <= EMPTY; read_data/read_src hold their last values.
- read_en while EMPTY: ignored, no state change.
- Write and read never occur in the same cycle; peak throughput is one item per 2 cycles.
- Latency: accept at edge N, read_rdy=1 after edge N. Pop at edge M, req_rdy can reassert after edge M.
- Fairness: a continuously requesting requester is granted within NREQ accepts.
- req_en deasserted before being granted is simply dropped from arbitration; no state is kept per requester.
- Outputs are all registered except req_rdy.

Optional Feature:
- Macro FIFO1_RR_ARBITER_GNT_CNT_EN.
- When defined:
  - Adds ports cnt_sel input IDW, cnt_clr input 1, cnt_val output 16.
  - Keeps one 16-bit counter per requester, incremented on each accept from that requester and saturating at 16'hFFFF.
  - cnt_val = counter[cnt_sel], combinational.
  - cnt_clr=1 zeroes all counters at the next edge; clear takes priority over a same-cycle increment.
  - Counters reset to 0 on RST.
- When undefined: the three ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: RST high 2 cycles, req_en=0 -> read_rdy=0, read_data=0, read_src=0, req_rdy=0.
- Single requester: NREQ=4, DW=8, req_en=4'b0100, data[2]=8'hA5 -> req_rdy=4'b0100, next cycle read_rdy=1, read_data=8'hA5, read_src=2. read_en=1 -> read_rdy=0 next cycle.
- Round-robin: all req_en=1, read_en=1 continuously -> accepted sources 0,1,2,3,0,… with one accept every 2 cycles.
- Back-pressure: FULL with read_en=0 for 10 cycles while all req_en=1 -> req_rdy=0 throughout; read_data stable; ptr unchanged.
- Wrap and skip: ptr=3, req_en=4'b0011 -> grant 0, then ptr=1 -> grant 1.
- Reset mid-operation: FULL with read_src=1, RST pulse -> state EMPTY, ptr=0; with GNT_CNT_EN, counters read 0. Saturation check: preload is not possible, so cnt_clr-vs-increment priority is checked instead.

Source files
------------

// File: rtl/fifo1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo1_rr_arbiter
//
// Round-robin arbiter in front of a single-entry holding buffer. NREQ
// producers compete with en/data/rdy write handshakes; one consumer drains
// the held item with read_en/read_data/read_rdy and also sees which
// requester wrote it (read_src).
//
// Ports:
//   CLK        in   1         clock, rising edge
//   RST        in   1         synchronous active-high reset
//   req_en     in   NREQ      per-requester write request
//   req_data   in   NREQ*DW   packed data, requester i at [i*DW +: DW]
//   req_rdy    out  NREQ      one-hot grant while empty, else zero (comb)
//   read_en    in   1         consumer pops the held item
//   read_data  out  DW        held data (registered)
//   read_src   out  IDW       requester index of held data (registered)
//   read_rdy   out  1         buffer holds a valid item (registered)
//
// Optional feature, enabled by defining FIFO1_RR_ARBITER_GNT_CNT_EN:
//   cnt_sel    in   IDW       selects which grant counter to show
//   cnt_clr    in   1         zero all counters (wins over an increment)
//   cnt_val    out  16        saturating accept count of requester cnt_sel
// ---------------------------------------------------------------------------
module fifo1_rr_arbiter #(
    parameter  int NREQ = 4,
    parameter  int DW   = 1,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_en,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_rdy,
    input  logic               read_en,
    output logic [DW-1:0]      read_data,
    output logic [IDW-1:0]     read_src,
`ifdef FIFO1_RR_ARBITER_GNT_CNT_EN
    input  logic [IDW-1:0]     cnt_sel,
    input  logic               cnt_clr,
    output logic [15:0]        cnt_val,
`endif
    output logic               read_rdy
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [DW-1:0]  r_data;
    logic [IDW-1:0] r_src;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_found;
    logic [IDW:0]    w_scan;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;
    logic [DW-1:0]   w_sel_data;

    // Rotating-priority scan: start at r_ptr and take the first requester
    // found, wrapping past NREQ-1 back to 0. One extra bit on w_scan keeps
    // the wrap compare exact for non-power-of-two NREQ.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(NREQ)) begin
                w_scan = w_scan - (IDW+1)'(NREQ);
            end
            if (!w_found && req_en[w_scan[IDW-1:0]]) begin
                w_found                 = 1'b1;
                w_gnt_idx               = w_scan[IDW-1:0];
                w_gnt[w_scan[IDW-1:0]]  = 1'b1;
            end
        end
    end

    assign w_accept   = (r_state == ST_EMPTY) && w_found;
    assign w_ptr_next = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_data = req_data[w_gnt_idx*DW +: DW];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_ptr   <= w_ptr_next;
            r_data  <= w_sel_data;
            r_src   <= w_gnt_idx;
        end else if ((r_state == ST_FULL) && read_en) begin
            // Pop: data/source stay visible, only validity drops.
            r_state <= ST_EMPTY;
        end
    end

    assign req_rdy   = (r_state == ST_EMPTY) ? w_gnt : '0;
    assign read_rdy  = (r_state == ST_FULL);
    assign read_data = r_data;
    assign read_src  = r_src;

`ifdef FIFO1_RR_ARBITER_GNT_CNT_EN
    logic [15:0] r_cnt [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cnt
            always_ff @(posedge CLK) begin
                if (RST || cnt_clr) begin
                    r_cnt[gi] <= '0;
                end else if (w_accept && (w_gnt_idx == IDW'(gi))
                             && (r_cnt[gi] != 16'hFFFF)) begin
                    r_cnt[gi] <= r_cnt[gi] + 16'd1;
                end
            end
        end
    endgenerate

    // Out-of-range selects (non-power-of-two NREQ) read as zero.
    assign cnt_val = (int'(cnt_sel) < NREQ) ? r_cnt[cnt_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_fifo1_rr_arbiter.sv
module tb_fifo1_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [NREQ-1:0]    req_en = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_rdy;
    logic               read_en = 1'b0;
    logic [DW-1:0]      read_data;
    logic [IDW-1:0]     read_src;
    logic               read_rdy;
`ifdef FIFO1_RR_ARBITER_GNT_CNT_EN
    logic [IDW-1:0]     cnt_sel = '0;
    logic               cnt_clr = 1'b0;
    logic [15:0]        cnt_val;
`endif

    fifo1_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_en    (req_en),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .read_en   (read_en),
        .read_data (read_data),
        .read_src  (read_src),
`ifdef FIFO1_RR_ARBITER_GNT_CNT_EN
        .cnt_sel   (cnt_sel),
        .cnt_clr   (cnt_clr),
        .cnt_val   (cnt_val),
`endif
        .read_rdy  (read_rdy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [NREQ-1:0]    en;
        logic [NREQ*DW-1:0] data;
        logic               rd;
        logic [NREQ-1:0]    exp_rdy;   // req_rdy before the edge
        logic               exp_valid; // read_rdy after the edge
        logic [DW-1:0]      exp_data;
        logic [IDW-1:0]     exp_src;
    } vec_t;

    vec_t vecs [11];

    localparam logic [31:0] D4 = 32'h44332211;

    initial begin
        // single requester 2 with A5 (ptr 0 -> 3)
        vecs[0]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[1]  = '{4'b0000, 32'h00A50000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
        // read_en while empty is ignored
        vecs[2]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
        // wrap and skip: ptr=3, en=0011 -> 0, then ptr=1 -> 1
        vecs[3]  = '{4'b0011, D4, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[4]  = '{4'b0011, D4, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        vecs[5]  = '{4'b0011, D4, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[6]  = '{4'b0011, D4, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1};
        // ptr=2, only requester 0 -> wrap to 0, ptr=1
        vecs[7]  = '{4'b0001, D4, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[8]  = '{4'b0000, D4, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        // ptr=1, only requester 3 -> ptr wraps to 0
        vecs[9]  = '{4'b1000, D4, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[10] = '{4'b0000, D4, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3};
    end

    initial begin
        // ---- reset then idle
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        $display("reset: read_rdy=%0b read_data=%h read_src=%0d req_rdy=%b",
                 read_rdy, read_data, read_src, req_rdy);
        chk("reset_read_rdy",  32'(read_rdy),  32'd0);
        chk("reset_read_data", 32'(read_data), 32'd0);
        chk("reset_read_src",  32'(read_src),  32'd0);
        chk("reset_req_rdy",   32'(req_rdy),   32'd0);
        tick();

        // ---- table-driven vectors
        for (int i = 0; i < 11; i++) begin
            req_en   = vecs[i].en;
            req_data = vecs[i].data;
            read_en  = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_req_rdy", i), 32'(req_rdy), 32'(vecs[i].exp_rdy));
            tick();
            $display("vec %0d: en=%b rd=%0b -> read_rdy=%0b data=%h src=%0d",
                     i, vecs[i].en, vecs[i].rd, read_rdy, read_data, read_src);
            chk($sformatf("v%0d_read_rdy", i),  32'(read_rdy),  32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_read_data", i), 32'(read_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_read_src", i),  32'(read_src),  32'(vecs[i].exp_src));
        end

        // ---- round-robin: all request, consumer always reading (ptr=0)
        req_en   = 4'b1111;
        req_data = D4;
        read_en  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                chk($sformatf("rr%0d_req_rdy", c), 32'(req_rdy), 32'(4'b0001 << (c / 2)));
            end else begin
                chk($sformatf("rr%0d_req_rdy", c), 32'(req_rdy), 32'd0);
            end
            tick();
            $display("rr cycle %0d: read_rdy=%0b src=%0d data=%h", c, read_rdy, read_src, read_data);
            chk($sformatf("rr%0d_read_rdy", c), 32'(read_rdy), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_read_src", c), 32'(read_src), 32'(c / 2));
        end

        // ---- back-pressure: accept from 0 (ptr -> 1) then hold FULL 10 cycles
        read_en = 1'b0;
        tick();
        chk("bp_accept_src", 32'(read_src), 32'd0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("bp%0d_req_rdy", c), 32'(req_rdy), 32'd0);
            tick();
            $display("bp cycle %0d: read_rdy=%0b data=%h", c, read_rdy, read_data);
            chk($sformatf("bp%0d_read_rdy", c),  32'(read_rdy),  32'd1);
            chk($sformatf("bp%0d_read_data", c), 32'(read_data), 32'h11);
        end
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        #1;
        chk("bp_ptr_kept_req_rdy", 32'(req_rdy), 32'b0010);
        tick();
        $display("after bp: read_rdy=%0b src=%0d data=%h", read_rdy, read_src, read_data);
        chk("bp_next_src",  32'(read_src),  32'd1);
        chk("bp_next_data", 32'(read_data), 32'h22);

        // ---- reset while FULL with read_src=1 (ptr=2)
        RST = 1'b1;
        tick();
        RST = 1'b0;
        $display("mid reset: read_rdy=%0b data=%h src=%0d", read_rdy, read_data, read_src);
        chk("mrst_read_rdy",  32'(read_rdy),  32'd0);
        chk("mrst_read_data", 32'(read_data), 32'd0);
        chk("mrst_read_src",  32'(read_src),  32'd0);
        #1;
        chk("mrst_ptr0_req_rdy", 32'(req_rdy), 32'b0001);

`ifdef FIFO1_RR_ARBITER_GNT_CNT_EN
        cnt_sel = 2'd0;
        #1;
        chk("cnt_after_reset", 32'(cnt_val), 32'd0);
        // accept from 0 with a same-cycle clear: clear wins
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("cnt_clr_priority", 32'(cnt_val), 32'd0);
        // pop, then req 0 only -> one counted accept
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        req_en  = 4'b0001;
        tick();
        #1;
        $display("cnt: sel=0 val=%0d", cnt_val);
        chk("cnt_increment", 32'(cnt_val), 32'd1);
`endif

        req_en = '0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
